thunderbird_monitor: RTL
========================

# thunderbird_monitor

- Receive-side checker for the Thunderbird tail-light sequencer.
- Samples the 3+3 lamp outputs every clock and decodes the signalling mode (idle, left sweep, right sweep, hazard).
- Checks every frame and every frame-to-frame transition against the legal lamp protocol, counts completed sweeps, and raises a sticky fault with a cause code.
- Sits on the same clock as the sequencer, driving dashboard indicators and a diagnostic status port.

## Interface
- `CNT_W`, default 8: width of the sweep counters.
- `TIMEOUT`, default 64: maximum consecutive non-idle cycles (used only with the watchdog macro).
- `CLK` in 1: the single clock.
- `Reset` in 1: synchronous, active-high reset.
- `Lin` in 3: left lamps. Bit 0 is innermost; lamps light 0→1→2.
- `Rin` in 3: right lamps. Bit 2 is innermost; lamps light 2→1→0.
- `mode` out 2: decoded mode. 00 idle, 01 left, 10 right, 11 hazard.
- `left_ind` out 1: dashboard left arrow. High when mode is 01 or 11.
- `right_ind` out 1: dashboard right arrow. High when mode is 10 or 11.
- `left_cnt` out CNT_W: completed left sweeps, saturating.
- `right_cnt` out CNT_W: completed right sweeps, saturating.
- `fault` out 1: sticky fault flag.
- `fault_code` out 2: cause of the first fault. 01 illegal frame, 10 illegal transition, 11 timeout.

## Operation
- Frames are written {Lin,Rin}, binary.
- Legal frames (9):
  - I = 000,000
  - L1 = 001,000; L2 = 011,000; L3 = 111,000
  - R1 = 000,100; R2 = 000,110; R3 = 000,111
  - HA = 010,101; HB = 101,010
- Previous-frame register `prev`, reset to I. Each cycle the current frame is classified and checked against `prev`.
- Legal transitions:
  - I → I, L1, R1, HA
  - L1 → L2, R1, HA; L2 → L3, R1, HA; L3 → I, R1, HA
  - R1 → R2, L1, HA; R2 → R3, L1, HA; R3 → I, L1, HA
  - HA → HB, L1, R1
  - HB → HA, I, L1, R1
- Any non-I frame repeated on consecutive cycles is an illegal transition.
- Frame not in the legal set:
  - Code 01.
  - `mode` holds its previous value.
  - `prev` is loaded with I, so checking resynchronises.
- Legal frame over an illegal transition: code 10. `mode` and `prev` update normally.
- Counters:
  - `left_cnt` increments on every cycle where `prev`=L3 and the current frame is legal. `right_cnt` likewise with `prev`=R3.
  - Both saturate at 2^CNT_W−1.
- Fault:
  - `fault` sets on the first violation and stays high until `Reset`.
  - `fault_code` latches the first cause. Later violations do not overwrite it.
  - Decoding and counting continue after a fault.
- Simultaneous causes in one cycle: priority 01 > 10 > 11.

## Timing
- All outputs are registered.
- A frame sampled at edge n is reflected in `mode`, indicators, counters and `fault` after edge n.
- Latency is one cycle.
- `Reset` high at an edge:
  - `mode`=00, indicators 0, counters 0, `fault`=0, `fault_code`=00, `prev`=I, watchdog count 0.
  - Applies regardless of any in-progress sweep or fault.
- First frame after `Reset` deasserts is checked against I. A sequencer reset in the same cycle therefore yields no fault.

## Configuration
- `THUNDERBIRD_MON_TIMEOUT_EN` defined:
  - A watchdog counter, clog2(TIMEOUT+1) bits, increments on every legal non-I frame. It clears on I or on an illegal frame.
  - When it would exceed `TIMEOUT`, fault code 11 is raised and the counter holds.
- Not defined:
  - No watchdog logic.
  - Code 11 is never produced.
  - `TIMEOUT` is ignored.

## Test plan
- Reset, then frames I,L1,L2,L3,I:
  - `mode` 00,01,01,01,00, each one cycle late.
  - `left_cnt`=1, `fault`=0.
- Frames R1,R2,R3,I,HA,HB,HA,HB,I:
  - `right_cnt`=1.
  - `mode` goes to 11 during HA/HB, with `left_ind`=`right_ind`=1.
  - `fault`=0.
- Frame I then 110,000:
  - `fault`=1, code 01, next cycle. `mode` holds 00.
  - Next frame L1 is accepted with no further code change.
- Frames L1,L3:
  - `fault`=1, code 10.
  - A subsequent illegal frame leaves `fault_code` at 10.
- With macro defined and `TIMEOUT`=4, run HA/HB alternation for 6 cycles:
  - Fault code 11 asserted after the 5th non-idle frame.
  - Without the macro, `fault` stays 0.
- `CNT_W`=2: five full left sweeps → `left_cnt` saturates at 3. Asserting `Reset` mid-sweep at L2 → all outputs zero the next cycle.

Source files
------------

// File: rtl/thunderbird_monitor_if.sv
// ============================================================================
// Module  : thunderbird_monitor_if
// Brief   : Lamp inputs and monitor result bundle for thunderbird_monitor.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface thunderbird_monitor_if #(
  parameter int CNT_W = 8
);
  logic [2:0]       Lin;
  logic [2:0]       Rin;
  logic [1:0]       mode;
  logic             left_ind;
  logic             right_ind;
  logic [CNT_W-1:0] left_cnt;
  logic [CNT_W-1:0] right_cnt;
  logic             fault;
  logic [1:0]       fault_code;

  modport master (
    output Lin, Rin,
    input  mode, left_ind, right_ind, left_cnt, right_cnt, fault, fault_code
  );

  modport slave (
    input  Lin, Rin,
    output mode, left_ind, right_ind, left_cnt, right_cnt, fault, fault_code
  );
endinterface

`default_nettype wire

// File: rtl/thunderbird_monitor.sv
// ============================================================================
// Module  : thunderbird_monitor
// Brief   : Lamp-protocol checker for the Thunderbird tail-light sequencer.
//           Optional watchdog enabled by defining THUNDERBIRD_MON_TIMEOUT_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module thunderbird_monitor #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                  CLK,
  input  logic                  Reset,
  thunderbird_monitor_if.slave  bus
);

  typedef enum logic [3:0] {
    FR_I, FR_L1, FR_L2, FR_L3, FR_R1, FR_R2, FR_R3, FR_HA, FR_HB, FR_BAD
  } frame_e;

  frame_e           prev_q, prev_d;
  frame_e           cur_frame;
  logic             trans_ok;
  logic             bad_frame;
  logic             bad_trans;
  logic             timeout_hit;
  logic [1:0]       mode_q, mode_d;
  logic             left_ind_q, left_ind_d;
  logic             right_ind_q, right_ind_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             fault_q, fault_d;
  logic [1:0]       code_q, code_d;

  function automatic logic [1:0] frame_mode(input frame_e f);
    logic [1:0] m;
    m = 2'b00;
    case (f)
      FR_L1, FR_L2, FR_L3: m = 2'b01;
      FR_R1, FR_R2, FR_R3: m = 2'b10;
      FR_HA, FR_HB:        m = 2'b11;
      default:             m = 2'b00;
    endcase
    return m;
  endfunction

  always_comb begin
    cur_frame = FR_BAD;
    case ({bus.Lin, bus.Rin})
      6'b000_000: cur_frame = FR_I;
      6'b001_000: cur_frame = FR_L1;
      6'b011_000: cur_frame = FR_L2;
      6'b111_000: cur_frame = FR_L3;
      6'b000_100: cur_frame = FR_R1;
      6'b000_110: cur_frame = FR_R2;
      6'b000_111: cur_frame = FR_R3;
      6'b010_101: cur_frame = FR_HA;
      6'b101_010: cur_frame = FR_HB;
      default:    cur_frame = FR_BAD;
    endcase
  end

  // Repeating any non-idle frame is absent from every list below, so it is illegal.
  always_comb begin
    trans_ok = 1'b0;
    case (prev_q)
      FR_I:  trans_ok = cur_frame inside {FR_I,  FR_L1, FR_R1, FR_HA};
      FR_L1: trans_ok = cur_frame inside {FR_L2, FR_R1, FR_HA};
      FR_L2: trans_ok = cur_frame inside {FR_L3, FR_R1, FR_HA};
      FR_L3: trans_ok = cur_frame inside {FR_I,  FR_R1, FR_HA};
      FR_R1: trans_ok = cur_frame inside {FR_R2, FR_L1, FR_HA};
      FR_R2: trans_ok = cur_frame inside {FR_R3, FR_L1, FR_HA};
      FR_R3: trans_ok = cur_frame inside {FR_I,  FR_L1, FR_HA};
      FR_HA: trans_ok = cur_frame inside {FR_HB, FR_L1, FR_R1};
      FR_HB: trans_ok = cur_frame inside {FR_HA, FR_I,  FR_L1, FR_R1};
      default: trans_ok = 1'b0;
    endcase
  end

  assign bad_frame = (cur_frame == FR_BAD);
  assign bad_trans = !bad_frame && !trans_ok;

`ifdef THUNDERBIRD_MON_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  always_comb begin
    wd_d        = wd_q;
    timeout_hit = 1'b0;
    if (bad_frame || cur_frame == FR_I) begin
      wd_d = '0;
    end else if (wd_q == WD_W'(TIMEOUT)) begin
      timeout_hit = 1'b1;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    prev_d = prev_q;
    mode_d = mode_q;
    lcnt_d = lcnt_q;
    rcnt_d = rcnt_q;
    fault_d = fault_q;
    code_d = code_q;

    // An unknown frame keeps the old mode and resynchronises checking to idle.
    if (bad_frame) begin
      prev_d = FR_I;
    end else begin
      prev_d = cur_frame;
      mode_d = frame_mode(cur_frame);
    end

    if (!bad_frame && prev_q == FR_L3 && lcnt_q != '1) lcnt_d = lcnt_q + CNT_W'(1);
    if (!bad_frame && prev_q == FR_R3 && rcnt_q != '1) rcnt_d = rcnt_q + CNT_W'(1);

    if (!fault_q) begin
      if (bad_frame) begin
        fault_d = 1'b1;
        code_d  = 2'b01;
      end else if (bad_trans) begin
        fault_d = 1'b1;
        code_d  = 2'b10;
      end else if (timeout_hit) begin
        fault_d = 1'b1;
        code_d  = 2'b11;
      end
    end

    left_ind_d  = mode_d[0];
    right_ind_d = mode_d[1];
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      prev_q      <= FR_I;
      mode_q      <= 2'b00;
      left_ind_q  <= 1'b0;
      right_ind_q <= 1'b0;
      lcnt_q      <= '0;
      rcnt_q      <= '0;
      fault_q     <= 1'b0;
      code_q      <= 2'b00;
    end else begin
      prev_q      <= prev_d;
      mode_q      <= mode_d;
      left_ind_q  <= left_ind_d;
      right_ind_q <= right_ind_d;
      lcnt_q      <= lcnt_d;
      rcnt_q      <= rcnt_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
    end
  end

  assign bus.mode       = mode_q;
  assign bus.left_ind   = left_ind_q;
  assign bus.right_ind  = right_ind_q;
  assign bus.left_cnt   = lcnt_q;
  assign bus.right_cnt  = rcnt_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;

endmodule

`default_nettype wire
